sensor_scan_ctrl: RTL and testbench
===================================

# sensor_scan_ctrl

Scan controller for the four active-low sensor LED select lines. It steps through the enabled channels in order 0→3, wrapping. On each channel it blanks all LEDs, drives the selected LED, and waits a programmable settle time. It then runs a request/acknowledge handshake with the sensor sampler, with a timeout. It sits between the register/config logic and the sensor LED pins, and replaces free-running cycling with a sequenced, sampled scan.

## Interface
- CNT_W, 16, width of the settle and timeout counters and config inputs
- BLANK_CYC, 2, cycles with all LEDs off before each channel is driven; minimum 1

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- i_enable  in  1  scan enable; sampled only in IDLE and NEXT
- i_ch_mask  in  4  channel enable mask, bit n = channel n; sampled only in IDLE and NEXT
- i_settle  in  CNT_W  settle cycles after the LED turns on; latched at BLANK entry; 0 is treated as 1
- i_timeout  in  CNT_W  maximum request cycles; latched at BLANK entry; 0 means no timeout
- i_sample_ack  in  1  sampler acknowledge; meaningful only while o_sample_req=1
- i_err_clr  in  1  clears o_err (all bits)
- o_sensor_LED  out  4  active-low LED selects; at most one bit is 0
- o_sample_req  out  1  sample request, held until ack or timeout
- o_ch  out  2  index of the current channel, valid while o_busy=1
- o_busy  out  1  1 in every state except IDLE
- o_frame_done  out  1  one-cycle pulse when a scan pass completes
- o_err  out  4  sticky per-channel timeout flags

## Operation
- States: IDLE, BLANK, SETTLE, SAMPLE, NEXT.
- Reset values: state IDLE, o_sensor_LED=4'b1111, o_sample_req=0, o_ch=0, o_busy=0, o_frame_done=0, o_err=0, counters 0.
- IDLE: LEDs 4'b1111. If i_enable=1 and i_ch_mask≠0, set o_ch to the lowest set mask bit, latch i_settle and i_timeout, go to BLANK. Otherwise stay in IDLE.
- BLANK: LEDs 4'b1111 for BLANK_CYC cycles, then go to SETTLE.
- SETTLE: bit o_ch of o_sensor_LED is 0, all other bits are 1. Stay for max(i_settle,1) cycles, then go to SAMPLE.
- SAMPLE: the LED stays on and o_sample_req=1.
  - i_sample_ack=1 ends the state.
  - If i_timeout≠0 and i_timeout request cycles elapse without ack, the state ends and o_err[o_ch] is set.
  - Ack and timeout on the same cycle count as ack: no error is set.
  - Either way, go to NEXT.
- NEXT (1 cycle): LEDs 4'b1111, o_sample_req=0. Search for the next set bit of i_ch_mask strictly after o_ch, wrapping past 3.
  - If the search wraps, or the found index is ≤ o_ch (this includes the single-channel case, where it finds o_ch itself), pulse o_frame_done.
  - If i_enable=0 or i_ch_mask=0, go to IDLE. The o_frame_done pulse is still given if the current channel was the last one in its pass.
  - Otherwise update o_ch, latch i_settle and i_timeout, and go to BLANK.
- Mask or enable changes outside IDLE and NEXT have no effect until the next NEXT. The current channel always completes.
- o_err: i_err_clr clears all bits. A timeout on the same cycle as i_err_clr wins: that bit is set.
- Reset asserted in any state returns everything to the reset values on the next edge. o_sample_req drops with no handshake completion.

## Timing
- Enable registered at edge E: BLANK occupies cycles E+1 … E+BLANK_CYC.
- With settle S (S≥1), SETTLE occupies the next S cycles.
- o_sample_req rises in the first SAMPLE cycle. Ack seen in the k-th request cycle (k≥1) gives req high for exactly k cycles. NEXT follows in the cycle after the ack.
- Per-channel period: BLANK_CYC + S + k + 1 cycles.
- The LED is never driven in BLANK or NEXT, so there is break-before-make with at least BLANK_CYC+1 off cycles between channels.
- o_frame_done is asserted in the NEXT cycle, coincident with the wrap.

## Test plan
- Reset mid-SAMPLE (req=1), rst_n=0 for 1 cycle → o_sensor_LED=4'b1111, o_sample_req=0, o_busy=0, o_err=0 on the next cycle.
- Mask 4'b0101, BLANK_CYC=2, settle=3, ack on 2nd req cycle, enable at cycle 0 → LED 4'b1110 in cycles 3–7, req in cycles 6–7, NEXT at 8. Then LED 4'b1011 from cycle 11. Frame_done pulses at the second NEXT (cycle 16).
- Mask 4'b1000, timeout=4, no ack → req high for 4 cycles, o_err=4'b1000, the scan continues on channel 3, o_frame_done every pass. i_err_clr=1 → o_err=0.
- Settle=0, timeout=0, ack delayed 50 cycles → one SETTLE cycle, req held 50 cycles, no error.
- Enable dropped during SETTLE of channel 1 (mask 4'b1111) → channel 1 still samples, then IDLE after NEXT. No o_frame_done.
- Ack and timeout on the same cycle (timeout=3, ack in 3rd cycle) → no error bit set.
- Throughout all scenarios: never more than one 0 in o_sensor_LED.

Source files
------------

// File: rtl/sensor_scan_ctrl.sv
// Purpose: sequenced scan of four active-low sensor LEDs with a sampler request/ack handshake per channel.
// Latency: per-channel period is BLANK_CYC + max(settle,1) + req cycles + 1 (NEXT); frame_done pulses in NEXT.
// Backpressure: o_sample_req is held until i_sample_ack or timeout; the scan stalls on the sampler meanwhile.
module sensor_scan_ctrl #(
  parameter int CNT_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [3:0]       i_ch_mask,
  input  logic [CNT_W-1:0] i_settle,
  input  logic [CNT_W-1:0] i_timeout,
  input  logic             i_sample_ack,
  input  logic             i_err_clr,
  output logic [3:0]       o_sensor_LED,
  output logic             o_sample_req,
  output logic [1:0]       o_ch,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [3:0]       o_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BLANK  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] settle_lat;
  logic [CNT_W-1:0] timeout_lat;
  logic [1:0]       ch;
  logic [3:0]       err;

  logic [CNT_W-1:0] settle_last;
  logic             timeout_hit;
  logic             pass_last;
  logic [3:0]       err_set;

  // Lowest set bit of the mask; callers only use it when the mask is non-zero.
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) res = 2'(i);
    end
    return res;
  endfunction

  // Next set bit strictly after cur, wrapping; offset 4 lands back on cur (single-channel case).
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) res = idx;
    end
    return res;
  endfunction

  // A settle of 0 behaves as 1; timeout compare is disabled when the latched timeout is 0.
  assign settle_last = (settle_lat == '0) ? '0 : settle_lat - CNT_W'(1);
  assign timeout_hit = (timeout_lat != '0) && (cnt == timeout_lat - CNT_W'(1));
  // No enabled channel above the current one means this NEXT closes the pass (search wraps).
  assign pass_last   = ~|(i_ch_mask & (4'b1110 << ch));
  // Ack takes priority over a coincident timeout.
  assign err_set     = (state == S_SAMPLE && !i_sample_ack && timeout_hit) ? (4'b0001 << ch) : 4'b0000;

  // Scan state machine, shared phase counter and per-channel config latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      settle_lat  <= '0;
      timeout_lat <= '0;
      ch          <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_enable && (i_ch_mask != 4'b0000)) begin
            ch          <= first_set(i_ch_mask);
            settle_lat  <= i_settle;
            timeout_lat <= i_timeout;
            state       <= S_BLANK;
          end
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == settle_last) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (i_sample_ack || timeout_hit) begin
            cnt   <= '0;
            state <= S_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_NEXT: begin
          cnt <= '0;
          if (!i_enable || (i_ch_mask == 4'b0000)) begin
            state <= S_IDLE;
          end else begin
            ch          <= next_set(i_ch_mask, ch);
            settle_lat  <= i_settle;
            timeout_lat <= i_timeout;
            state       <= S_BLANK;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flags; a timeout set in the same cycle as a clear survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 4'b0000;
    end else begin
      err <= (i_err_clr ? 4'b0000 : err) | err_set;
    end
  end

  // LED is driven only in SETTLE and SAMPLE, giving break-before-make through BLANK and NEXT.
  assign o_sensor_LED = (state == S_SETTLE || state == S_SAMPLE) ? ~(4'b0001 << ch) : 4'b1111;
  assign o_sample_req = (state == S_SAMPLE);
  assign o_ch         = ch;
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = (state == S_NEXT) && pass_last;
  assign o_err        = err;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl: cycle n is the clock period ending at edge n.
// Outputs are checked at the falling edge of cycle n; inputs for cycle n are then driven
// so that they are sampled at the rising edge that ends cycle n.
module tb_sensor_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [3:0]  i_ch_mask;
  logic [15:0] i_settle;
  logic [15:0] i_timeout;
  logic        i_sample_ack;
  logic        i_err_clr;
  logic [3:0]  o_sensor_LED;
  logic        o_sample_req;
  logic [1:0]  o_ch;
  logic        o_busy;
  logic        o_frame_done;
  logic [3:0]  o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int reqc;

  always #5 clk = ~clk;

  sensor_scan_ctrl #(.CNT_W(16), .BLANK_CYC(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_ch_mask    (i_ch_mask),
    .i_settle     (i_settle),
    .i_timeout    (i_timeout),
    .i_sample_ack (i_sample_ack),
    .i_err_clr    (i_err_clr),
    .o_sensor_LED (o_sensor_LED),
    .o_sample_req (o_sample_req),
    .o_ch         (o_ch),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // At most one LED may be driven low at any time.
  always @(negedge clk) begin
    check("led_onecold", {15'd0, ($countones(~o_sensor_LED) <= 32'd1)}, 16'd1);
  end

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_ch_mask = 4'b0000; i_settle = 16'd0;
    i_timeout = 16'd0; i_sample_ack = 1'b0; i_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led",  16'(o_sensor_LED), 16'hF);
    check("rst_req",  16'(o_sample_req), 16'd0);
    check("rst_busy", 16'(o_busy),       16'd0);
    check("rst_fd",   16'(o_frame_done), 16'd0);
    check("rst_err",  16'(o_err),        16'd0);
    check("rst_ch",   16'(o_ch),         16'd0);
    rst_n = 1'b1;

    // Mask 0101, settle 3, ack on 2nd request cycle of each channel.
    i_ch_mask = 4'b0101; i_settle = 16'd3; i_timeout = 16'd0;
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      case (n)
        0:  check("s2_idle_busy", 16'(o_busy), 16'd0);
        2:  begin check("s2_blank_led", 16'(o_sensor_LED), 16'hF);
                  check("s2_blank_busy", 16'(o_busy), 16'd1);
                  check("s2_blank_ch", 16'(o_ch), 16'd0); end
        3:  check("s2_settle_led", 16'(o_sensor_LED), 16'hE);
        5:  begin check("s2_settle5_led", 16'(o_sensor_LED), 16'hE);
                  check("s2_settle5_req", 16'(o_sample_req), 16'd0); end
        6:  check("s2_req6", 16'(o_sample_req), 16'd1);
        7:  begin check("s2_led7", 16'(o_sensor_LED), 16'hE);
                  check("s2_req7", 16'(o_sample_req), 16'd1);
                  check("s2_fd7", 16'(o_frame_done), 16'd0); end
        8:  begin check("s2_next_led", 16'(o_sensor_LED), 16'hF);
                  check("s2_next_req", 16'(o_sample_req), 16'd0);
                  check("s2_next_fd", 16'(o_frame_done), 16'd0); end
        11: begin check("s2_ch2_led", 16'(o_sensor_LED), 16'hB);
                  check("s2_ch2", 16'(o_ch), 16'd2); end
        13: begin check("s2_led13", 16'(o_sensor_LED), 16'hB);
                  check("s2_req13", 16'(o_sample_req), 16'd0); end
        15: check("s2_req15", 16'(o_sample_req), 16'd1);
        16: begin check("s2_wrap_fd", 16'(o_frame_done), 16'd1);
                  check("s2_wrap_led", 16'(o_sensor_LED), 16'hF); end
        17: check("s2_end_busy", 16'(o_busy), 16'd0);
        default: ;
      endcase
      i_enable     = (n < 16);
      i_sample_ack = (n == 7 || n == 15);
    end

    // Mask 1000, timeout 4, never ack; err clear alone, then coincident with a timeout; reset mid-SAMPLE.
    i_ch_mask = 4'b1000; i_settle = 16'd1; i_timeout = 16'd4; reqc = 0;
    for (int n = 0; n <= 21; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= 8 && o_sample_req) reqc++;
      case (n)
        3:  begin check("s3_ch", 16'(o_ch), 16'd3);
                  check("s3_led", 16'(o_sensor_LED), 16'h7); end
        7:  begin check("s3_err_pre", 16'(o_err), 16'd0);
                  check("s3_fd_pre", 16'(o_frame_done), 16'd0);
                  check("s3_req_last", 16'(o_sample_req), 16'd1); end
        8:  begin check("s3_err_set", 16'(o_err), 16'h8);
                  check("s3_fd_pass1", 16'(o_frame_done), 16'd1);
                  check("s3_req_cycles", 16'(reqc), 16'd4); end
        10: check("s3_err_clr", 16'(o_err), 16'd0);
        16: begin check("s3_err_set_wins", 16'(o_err), 16'h8);
                  check("s3_fd_pass2", 16'(o_frame_done), 16'd1); end
        20: check("s3_req_before_rst", 16'(o_sample_req), 16'd1);
        21: begin check("s3_rst_led", 16'(o_sensor_LED), 16'hF);
                  check("s3_rst_req", 16'(o_sample_req), 16'd0);
                  check("s3_rst_busy", 16'(o_busy), 16'd0);
                  check("s3_rst_err", 16'(o_err), 16'd0);
                  check("s3_rst_ch", 16'(o_ch), 16'd0); end
        default: ;
      endcase
      i_enable     = (n < 21);
      i_sample_ack = 1'b0;
      i_err_clr    = (n == 9 || n == 15);
      rst_n        = !(n == 20);
    end

    // Settle 0 behaves as 1; no timeout; ack after 50 request cycles.
    i_ch_mask = 4'b0001; i_settle = 16'd0; i_timeout = 16'd0; reqc = 0;
    for (int n = 0; n <= 55; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= 54 && o_sample_req) reqc++;
      case (n)
        3:  begin check("s4_settle_led", 16'(o_sensor_LED), 16'hE);
                  check("s4_settle_req", 16'(o_sample_req), 16'd0); end
        4:  check("s4_req_first", 16'(o_sample_req), 16'd1);
        53: check("s4_req_last", 16'(o_sample_req), 16'd1);
        54: begin check("s4_next_req", 16'(o_sample_req), 16'd0);
                  check("s4_err", 16'(o_err), 16'd0);
                  check("s4_fd", 16'(o_frame_done), 16'd1);
                  check("s4_req_cycles", 16'(reqc), 16'd50); end
        55: check("s4_end_busy", 16'(o_busy), 16'd0);
        default: ;
      endcase
      i_enable     = (n < 54);
      i_sample_ack = (n == 53);
    end

    // Mask 1111, enable dropped during SETTLE of channel 1: channel 1 completes, no frame_done.
    i_ch_mask = 4'b1111; i_settle = 16'd2; i_timeout = 16'd0;
    for (int n = 0; n <= 13; n++) begin
      @(negedge clk);
      case (n)
        5:  begin check("s5_req_ch0", 16'(o_sample_req), 16'd1);
                  check("s5_ch0", 16'(o_ch), 16'd0); end
        6:  begin check("s5_fd_ch0", 16'(o_frame_done), 16'd0);
                  check("s5_next_led", 16'(o_sensor_LED), 16'hF); end
        9:  begin check("s5_ch1", 16'(o_ch), 16'd1);
                  check("s5_ch1_led", 16'(o_sensor_LED), 16'hD); end
        11: begin check("s5_ch1_req", 16'(o_sample_req), 16'd1);
                  check("s5_ch1_led_smp", 16'(o_sensor_LED), 16'hD); end
        12: begin check("s5_fd_ch1", 16'(o_frame_done), 16'd0);
                  check("s5_next_req", 16'(o_sample_req), 16'd0);
                  check("s5_next_busy", 16'(o_busy), 16'd1); end
        13: check("s5_idle_busy", 16'(o_busy), 16'd0);
        default: ;
      endcase
      i_enable     = (n < 9);
      i_sample_ack = (n == 5 || n == 11);
    end

    // Timeout 3 with ack in the 3rd request cycle: ack wins, no error.
    i_ch_mask = 4'b0010; i_settle = 16'd1; i_timeout = 16'd3; reqc = 0;
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      if (n >= 1 && n <= 7 && o_sample_req) reqc++;
      case (n)
        3:  begin check("s6_led", 16'(o_sensor_LED), 16'hD);
                  check("s6_ch", 16'(o_ch), 16'd1); end
        6:  check("s6_req3", 16'(o_sample_req), 16'd1);
        7:  begin check("s6_err", 16'(o_err), 16'd0);
                  check("s6_fd", 16'(o_frame_done), 16'd1);
                  check("s6_next_req", 16'(o_sample_req), 16'd0);
                  check("s6_req_cycles", 16'(reqc), 16'd3); end
        8:  check("s6_idle_busy", 16'(o_busy), 16'd0);
        default: ;
      endcase
      i_enable     = (n < 7);
      i_sample_ack = (n == 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
